// File: rtl/flt2int_pipe.sv
// ---------------------------------------------------------------------------
// flt2int_pipe
//   Two-stage pipelined float-to-integer converter.
//   Input operand:  value = (-1)^sign * 0.mant * 2^exp
//   Output result:  sign-magnitude integer {sign, magnitude[IW-2:0]} with
//                   overflow/underflow flags and sticky status flags.
//   Valid/ready handshakes on both sides; a slow consumer stalls the pipe
//   without bubbles or data loss.
//
// Parameters
//   EW  exponent width (unsigned, no bias)
//   MW  mantissa width, MSB weight 0.5 (MW >= 1)
//   IW  output width, bit IW-1 is the sign (IW >= 2)
//
// Build option
//   FLT2INT_ROUND_EN  defined: round-half-to-even on the dropped fraction.
//                     undefined: truncation toward zero (default).
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    in_a holds a valid operand
//   in_ready    operand accepted this cycle
//   in_a        {sign, exp[EW-1:0], mant[MW-1:0]}
//   out_valid   out_* holds a valid result
//   out_ready   consumer accepts the result this cycle
//   out_r       {sign, magnitude[IW-2:0]}
//   out_of      result saturated (value too large)
//   out_uf      |value| < 1 (exp == 0)
//   sticky_of   set by any transferred result with out_of = 1
//   sticky_uf   set by any transferred result with out_uf = 1
//   clr_sticky  synchronous clear of both sticky flags (wins over a set)
// ---------------------------------------------------------------------------
module flt2int_pipe #(
  parameter int EW = 4,
  parameter int MW = 8,
  parameter int IW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_r,
  output logic             out_of,
  output logic             out_uf,
  output logic             sticky_of,
  output logic             sticky_uf,
  input  logic             clr_sticky
);

  localparam int SW = $clog2(IW);
  localparam int PW = MW + IW - 1;

`ifdef FLT2INT_ROUND_EN
  localparam logic [MW-1:0] HALF = MW'(1) << (MW - 1);

  // Adds the half-to-even increment; the MSB of the result is the carry
  // out of the magnitude field.
  function automatic logic [IW-1:0] round_hte(input logic [IW-2:0] ip,
                                              input logic [MW-1:0] fr);
    logic up;
    up = (fr > HALF) || ((fr == HALF) && ip[0]);
    return {1'b0, ip} + IW'(up);
  endfunction
`endif

  function automatic logic [IW-2:0] sat_mag(input logic ovf,
                                            input logic [IW-2:0] m);
    return ovf ? '1 : m;
  endfunction

  // Handshake control
  logic vld_p1;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_load;

  // Operand decode and range classification
  logic          sign_in;
  logic [EW-1:0] exp_in;
  logic [MW-1:0] mant_in;
  logic [31:0]   exp_w;
  logic          uf_in;
  logic          of_in;
  logic [SW-1:0] sh_in;

  assign sign_in = in_a[EW+MW];
  assign exp_in  = in_a[EW+MW-1:MW];
  assign mant_in = in_a[MW-1:0];
  assign exp_w   = 32'(exp_in);
  assign uf_in   = (exp_w == 32'd0);
  assign of_in   = (exp_w >= 32'(IW));
  // In-range exponents are at most IW-1, so they fit SW bits unchanged.
  assign sh_in   = of_in ? '0 : SW'(exp_in);

  // ---- Stage 1: captured operand, shift amount and range class ----
  logic          sign_p1;
  logic          uf_p1;
  logic          of_p1;
  logic [MW-1:0] mant_p1;
  logic [SW-1:0] sh_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      sign_p1 <= sign_in;
      uf_p1   <= uf_in;
      of_p1   <= of_in;
      mant_p1 <= mant_in;
      sh_p1   <= sh_in;
    end
  end

  // 0.mant * 2^e as a fixed-point value with MW fraction bits: the integer
  // part sits above bit MW-1, the dropped fraction below it.
  logic [PW-1:0]   prod_c;
  logic [IW-2:0]   ip_c;
  logic [IW-2:0]   mag_c;
  logic            of_c;

  assign prod_c = PW'(mant_p1) << sh_p1;
  assign ip_c   = prod_c[PW-1:MW];

`ifdef FLT2INT_ROUND_EN
  logic [IW-1:0] rnd_c;

  assign rnd_c = round_hte(ip_c, prod_c[MW-1:0]);
  assign of_c  = of_p1 | rnd_c[IW-1];
  assign mag_c = sat_mag(of_c, rnd_c[IW-2:0]);
`else
  logic unused_frac;

  assign unused_frac = ^prod_c[MW-1:0];
  assign of_c        = of_p1;
  assign mag_c       = sat_mag(of_c, ip_c);
`endif

  // ---- Stage 2: shifted, rounded and saturated result ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_of    <= 1'b0;
      out_uf    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_r  <= {sign_p1, mag_c};
        out_of <= of_c;
        out_uf <= uf_p1;
      end
    end
  end

  // Sticky status, updated only on an output transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_of <= 1'b0;
      sticky_uf <= 1'b0;
    end else if (clr_sticky) begin
      sticky_of <= 1'b0;
      sticky_uf <= 1'b0;
    end else if (out_valid && out_ready) begin
      sticky_of <= sticky_of | out_of;
      sticky_uf <= sticky_uf | out_uf;
    end
  end

endmodule

// File: tb/tb_flt2int_pipe.sv
module tb_flt2int_pipe;

  localparam int EW = 4;
  localparam int MW = 8;
  localparam int IW = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [EW+MW:0]    in_a = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [IW-1:0]     out_r;
  logic              out_of;
  logic              out_uf;
  logic              sticky_of;
  logic              sticky_uf;
  logic              clr_sticky = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  flt2int_pipe #(.EW(EW), .MW(MW), .IW(IW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_of     (out_of),
    .out_uf     (out_uf),
    .sticky_of  (sticky_of),
    .sticky_uf  (sticky_uf),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  // Single operand through an empty pipe with out_ready held high.
  // Leaves the bench one cycle after the output transfer (sticky updated).
  task automatic xfer_single(input logic [EW+MW:0] a, input logic [IW-1:0] er,
                             input logic eof, input logic euf, input string nm);
    in_a      = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_lat1: out_valid=%b expected 0", nm, out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_lat2: out_valid=%b expected 1", nm, out_valid);
    end
    n_checks++;
    if (out_r !== er) begin
      n_fail++; $display("FAIL %s_r: out_r=%h expected %h", nm, out_r, er);
    end
    n_checks++;
    if (out_of !== eof) begin
      n_fail++; $display("FAIL %s_of: out_of=%b expected %b", nm, out_of, eof);
    end
    n_checks++;
    if (out_uf !== euf) begin
      n_fail++; $display("FAIL %s_uf: out_uf=%b expected %b", nm, out_uf, euf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid: out_valid=%b expected 0", out_valid);
    end
    n_checks++;
    if ({out_r, out_of, out_uf, sticky_of, sticky_uf} !== '0) begin
      n_fail++; $display("FAIL rst_outs: r=%h of=%b uf=%b sof=%b suf=%b expected all 0",
                         out_r, out_of, out_uf, sticky_of, sticky_uf);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_ready: in_ready=%b expected 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic();
`ifdef FLT2INT_ROUND_EN
    xfer_single({1'b0, 4'd3, 8'b1011_0000}, 8'h06, 1'b0, 1'b0, "basic");
`else
    xfer_single({1'b0, 4'd3, 8'b1011_0000}, 8'h05, 1'b0, 1'b0, "basic");
`endif
  endtask

  task automatic test_neg_max();
`ifdef FLT2INT_ROUND_EN
    // 127.5 rounds to 128, which carries past the magnitude range
    xfer_single({1'b1, 4'd7, 8'hFF}, 8'hFF, 1'b1, 1'b0, "negmax");
`else
    xfer_single({1'b1, 4'd7, 8'hFF}, 8'hFF, 1'b0, 1'b0, "negmax");
    n_checks++;
    if (sticky_of !== 1'b0) begin
      n_fail++; $display("FAIL negmax_sticky: sticky_of=%b expected 0", sticky_of);
    end
`endif
  endtask

  task automatic test_overflow();
    xfer_single({1'b0, 4'd8, 8'h80}, 8'h7F, 1'b1, 1'b0, "ovf");
    n_checks++;
    if (sticky_of !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: sticky_of=%b expected 1", sticky_of);
    end
    n_checks++;
    if (sticky_uf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky_uf: sticky_uf=%b expected 0", sticky_uf);
    end
  endtask

  task automatic test_underflow();
`ifdef FLT2INT_ROUND_EN
    xfer_single({1'b1, 4'd0, 8'hC0}, 8'h81, 1'b0, 1'b1, "uf_neg");
    xfer_single({1'b0, 4'd0, 8'h80}, 8'h00, 1'b0, 1'b1, "uf_half");
`else
    xfer_single({1'b1, 4'd0, 8'hC0}, 8'h80, 1'b0, 1'b1, "uf_neg");
`endif
    n_checks++;
    if (sticky_uf !== 1'b1) begin
      n_fail++; $display("FAIL uf_sticky: sticky_uf=%b expected 1", sticky_uf);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW+MW:0] vec [8];
    logic [IW-1:0]  expv [8];
    int   idx    = 0;
    int   ridx   = 0;
    int   occ    = 0;
    bit   hold_f = 1'b0;
    bit   in_x;
    bit   out_x;
    logic [IW-1:0] held = '0;
    vec[0] = {1'b0, 4'd1, 8'h80}; expv[0] = 8'h01;
    vec[1] = {1'b0, 4'd2, 8'hC0}; expv[1] = 8'h03;
    vec[2] = {1'b1, 4'd3, 8'hA0}; expv[2] = 8'h85;
    vec[3] = {1'b0, 4'd4, 8'hF0}; expv[3] = 8'h0F;
    vec[4] = {1'b1, 4'd5, 8'h88}; expv[4] = 8'h91;
    vec[5] = {1'b0, 4'd6, 8'hC4}; expv[5] = 8'h31;
    vec[6] = {1'b0, 4'd7, 8'hFE}; expv[6] = 8'h7F;
    vec[7] = {1'b1, 4'd2, 8'h40}; expv[7] = 8'h81;
    for (int c = 0; c < 100 && ridx < 8; c++) begin
      @(posedge clk); #1;
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      in_valid  = (idx < 8);
      if (idx < 8) in_a = vec[idx];
      @(negedge clk);
      if (hold_f) begin
        n_checks++;
        if (out_r !== held || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_hold: out_r=%h valid=%b expected %h held valid", out_r, out_valid, held);
        end
      end
      n_checks++;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready: cycle %0d in_ready=%b expected %b",
                           c, in_ready, !(occ == 2 && !out_ready));
      end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        n_checks++;
        if (out_r !== expv[ridx]) begin
          n_fail++; $display("FAIL b2b_data%0d: out_r=%h expected %h", ridx, out_r, expv[ridx]);
        end
        ridx++;
      end
      hold_f = out_valid && !out_ready;
      held   = out_r;
      occ    = occ + int'(in_x) - int'(out_x);
      idx    = idx + int'(in_x);
    end
    n_checks++;
    if (ridx != 8) begin
      n_fail++; $display("FAIL b2b_count: received %0d results expected 8", ridx);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = {1'b0, 4'd8, 8'h80};
    @(posedge clk); #1;
    in_a = {1'b0, 4'd3, 8'hA0};
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_prefill: out_valid=%b expected 1", out_valid);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: out_valid=%b expected 0", out_valid);
    end
    n_checks++;
    if ({out_r, out_of, sticky_of, sticky_uf} !== '0) begin
      n_fail++; $display("FAIL mid_outs: r=%h of=%b sof=%b suf=%b expected all 0",
                         out_r, out_of, sticky_of, sticky_uf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale%0d: out_valid=%b expected 0", c, out_valid);
      end
    end
  endtask

  task automatic test_clear_sticky();
    in_a      = {1'b0, 4'd9, 8'h80};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_of !== 1'b1) begin
      n_fail++; $display("FAIL clr_result: valid=%b of=%b expected 1 1", out_valid, out_of);
    end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    n_checks++;
    if (sticky_of !== 1'b0) begin
      n_fail++; $display("FAIL clr_priority: sticky_of=%b expected 0", sticky_of);
    end
    xfer_single({1'b1, 4'd10, 8'h80}, 8'hFF, 1'b1, 1'b0, "of2");
    n_checks++;
    if (sticky_of !== 1'b1) begin
      n_fail++; $display("FAIL clr_reset: sticky_of=%b expected 1", sticky_of);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_max();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_midflight();
    test_clear_sticky();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
